// File: rtl/axi_bridge_nch.sv
// axi_bridge_nch: bridges NUM_CH SRAM-like request channels onto one AXI3 master.
// Channel i uses AXI ID i. Each channel has at most one outstanding transaction.
// Reads and writes are arbitrated separately, each with its own round-robin pointer.
// The single AR slot and the write FSM run concurrently.
// A read is held back while a write to the same word is in flight.
// Ports:
//   aclk/aresetn                       clock, asynchronous active-low reset
//   ch_req/ch_wr/ch_size/ch_addr       per-channel request (packed NUM_CH-wide buses)
//   ch_wstrb/ch_wdata                  per-channel write strobes and data
//   ch_addr_ok                         request accepted (combinational, same cycle)
//   ch_data_ok/ch_rdata                one-cycle completion pulse and read data
//   ar*/r*/aw*/w*/b*                   AXI3 master channels, single-beat bursts only
module axi_bridge_nch #(
  parameter int unsigned NUM_CH = 2
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [NUM_CH-1:0]     ch_req,
  input  logic [NUM_CH-1:0]     ch_wr,
  input  logic [2*NUM_CH-1:0]   ch_size,
  input  logic [32*NUM_CH-1:0]  ch_addr,
  input  logic [4*NUM_CH-1:0]   ch_wstrb,
  input  logic [32*NUM_CH-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]     ch_addr_ok,
  output logic [NUM_CH-1:0]     ch_data_ok,
  output logic [32*NUM_CH-1:0]  ch_rdata,
  output logic [3:0]            arid,
  output logic [31:0]           araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  output logic [1:0]            arlock,
  output logic [3:0]            arcache,
  output logic [2:0]            arprot,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [3:0]            rid,
  input  logic [31:0]           rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [3:0]            awid,
  output logic [31:0]           awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic [1:0]            awlock,
  output logic [3:0]            awcache,
  output logic [2:0]            awprot,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [3:0]            wid,
  output logic [31:0]           wdata,
  output logic [3:0]            wstrb,
  output logic                  wlast,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [3:0]            bid,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_REQ  = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  w_state_e              w_state_q, w_state_d;
  logic [NUM_CH-1:0]     busy_q, busy_d;
  logic [NUM_CH-1:0]     rd_own_q, rd_own_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [1:0]            wr_ptr_q, wr_ptr_d;

  logic                  arvalid_q, arvalid_d;
  logic [1:0]            ar_ch_q, ar_ch_d;
  logic [31:0]           araddr_q, araddr_d;
  logic [1:0]            ar_size_q, ar_size_d;
  logic                  rready_q, rready_d;

  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [1:0]            w_ch_q, w_ch_d;
  logic [31:0]           awaddr_q, awaddr_d;
  logic [1:0]            aw_size_q, aw_size_d;
  logic [3:0]            wstrb_q, wstrb_d;
  logic [31:0]           wdata_q, wdata_d;

  logic [NUM_CH-1:0]     data_ok_q, data_ok_d;
  logic [32*NUM_CH-1:0]  rdata_q, rdata_d;

  logic [NUM_CH-1:0]     hazard, rd_cand, wr_cand, rd_gnt, wr_gnt;

  // Responses carry no error handling; these inputs are intentionally ignored.
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast, bresp, bid};

  // Round-robin pick: first candidate at or above ptr, else wrap to the lowest.
  function automatic logic [NUM_CH-1:0] rr_pick(input logic [NUM_CH-1:0] cand,
                                                input logic [1:0] ptr);
    logic [NUM_CH-1:0] g;
    logic              found;
    g     = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && cand[i] && (i >= 32'(ptr))) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (!found && cand[i]) begin
        g[i]  = 1'b1;
        found = 1'b1;
      end
    end
    return g;
  endfunction

  always_comb begin
    hazard  = '0;
    rd_cand = '0;
    wr_cand = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hazard[i]  = (w_state_q != W_IDLE) && (ch_addr[32*i+2 +: 30] == awaddr_q[31:2]);
      rd_cand[i] = ch_req[i] & ~ch_wr[i] & ~busy_q[i] & ~hazard[i];
      wr_cand[i] = ch_req[i] &  ch_wr[i] & ~busy_q[i];
    end
  end

  // Grants are gated by aresetn so addr_ok stays low while reset is asserted.
  assign rd_gnt     = (aresetn && !arvalid_q) ? rr_pick(rd_cand, rd_ptr_q) : '0;
  assign wr_gnt     = (aresetn && (w_state_q == W_IDLE)) ? rr_pick(wr_cand, wr_ptr_q) : '0;
  assign ch_addr_ok = rd_gnt | wr_gnt;

  always_comb begin
    w_state_d = w_state_q;
    busy_d    = busy_q;
    rd_own_d  = rd_own_q;
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    arvalid_d = arvalid_q;
    ar_ch_d   = ar_ch_q;
    araddr_d  = araddr_q;
    ar_size_d = ar_size_q;
    rready_d  = 1'b1;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    w_ch_d    = w_ch_q;
    awaddr_d  = awaddr_q;
    aw_size_d = aw_size_q;
    wstrb_d   = wstrb_q;
    wdata_d   = wdata_q;
    data_ok_d = '0;
    rdata_d   = rdata_q;

    // AR slot: load on grant (only possible while empty), drain on handshake.
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if (rd_gnt[i]) begin
        arvalid_d   = 1'b1;
        ar_ch_d     = 2'(i);
        araddr_d    = ch_addr[32*i +: 32];
        ar_size_d   = ch_size[2*i +: 2];
        busy_d[i]   = 1'b1;
        rd_own_d[i] = 1'b1;
        rd_ptr_d    = 2'((i + 1) % NUM_CH);
      end
    end
    if (arvalid_q && arready) begin
      arvalid_d = 1'b0;
    end

    // R: only a channel with an outstanding read accepts the beat; others are dropped.
    if (rvalid && rready_q) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if ((rid == 4'(i)) && busy_q[i] && rd_own_q[i]) begin
          data_ok_d[i]         = 1'b1;
          rdata_d[32*i +: 32]  = rdata;
          busy_d[i]            = 1'b0;
        end
      end
    end

    case (w_state_q)
      W_IDLE: begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          if (wr_gnt[i]) begin
            w_state_d   = W_REQ;
            awvalid_d   = 1'b1;
            wvalid_d    = 1'b1;
            w_ch_d      = 2'(i);
            awaddr_d    = ch_addr[32*i +: 32];
            aw_size_d   = ch_size[2*i +: 2];
            wstrb_d     = ch_wstrb[4*i +: 4];
            wdata_d     = ch_wdata[32*i +: 32];
            busy_d[i]   = 1'b1;
            rd_own_d[i] = 1'b0;
            wr_ptr_d    = 2'((i + 1) % NUM_CH);
          end
        end
      end
      W_REQ: begin
        // AW and W complete independently, in either order or together.
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid) begin
          w_state_d = W_IDLE;
          for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (w_ch_q == 2'(i)) begin
              data_ok_d[i] = 1'b1;
              busy_d[i]    = 1'b0;
            end
          end
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_state_q <= W_IDLE;
      busy_q    <= '0;
      rd_own_q  <= '0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      arvalid_q <= 1'b0;
      ar_ch_q   <= '0;
      araddr_q  <= '0;
      ar_size_q <= '0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      w_ch_q    <= '0;
      awaddr_q  <= '0;
      aw_size_q <= '0;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      data_ok_q <= '0;
      rdata_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      busy_q    <= busy_d;
      rd_own_q  <= rd_own_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      arvalid_q <= arvalid_d;
      ar_ch_q   <= ar_ch_d;
      araddr_q  <= araddr_d;
      ar_size_q <= ar_size_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      w_ch_q    <= w_ch_d;
      awaddr_q  <= awaddr_d;
      aw_size_q <= aw_size_d;
      wstrb_q   <= wstrb_d;
      wdata_q   <= wdata_d;
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign arid       = {2'b00, ar_ch_q};
  assign araddr     = araddr_q;
  assign arlen      = 8'd0;
  assign arsize     = {1'b0, ar_size_q};
  assign arburst    = 2'b01;
  assign arlock     = 2'b00;
  assign arcache    = 4'b0000;
  assign arprot     = 3'b000;
  assign arvalid    = arvalid_q;
  assign rready     = rready_q;

  assign awid       = {2'b00, w_ch_q};
  assign awaddr     = awaddr_q;
  assign awlen      = 8'd0;
  assign awsize     = {1'b0, aw_size_q};
  assign awburst    = 2'b01;
  assign awlock     = 2'b00;
  assign awcache    = 4'b0000;
  assign awprot     = 3'b000;
  assign awvalid    = awvalid_q;

  assign wid        = {2'b00, w_ch_q};
  assign wdata      = wdata_q;
  assign wstrb      = wstrb_q;
  assign wlast      = 1'b1;
  assign wvalid     = wvalid_q;
  assign bready     = (w_state_q == W_RESP);

  assign ch_data_ok = data_ok_q;
  assign ch_rdata   = rdata_q;

endmodule

// File: tb/tb_axi_bridge_nch.sv
module tb_axi_bridge_nch;

  localparam int unsigned NCH = 2;

  logic            aclk, aresetn;
  logic [NCH-1:0]  ch_req, ch_wr, ch_addr_ok, ch_data_ok;
  logic [2*NCH-1:0]  ch_size;
  logic [32*NCH-1:0] ch_addr, ch_wdata, ch_rdata;
  logic [4*NCH-1:0]  ch_wstrb;
  logic [3:0]  arid, awid, wid, rid, bid, arcache, awcache, wstrb;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  axi_bridge_nch #(.NUM_CH(NCH)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ch_req(ch_req), .ch_wr(ch_wr), .ch_size(ch_size), .ch_addr(ch_addr),
    .ch_wstrb(ch_wstrb), .ch_wdata(ch_wdata),
    .ch_addr_ok(ch_addr_ok), .ch_data_ok(ch_data_ok), .ch_rdata(ch_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  typedef struct packed {
    bit          is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   n_cmp = 0;
  int   n_err = 0;

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int c, input bit rd, input logic [31:0] d);
    exp_t e;
    e.is_rd = rd;
    e.data  = d;
    if (c == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic mon_check(input int c, input logic [31:0] act);
    exp_t e;
    bit   have;
    have = 1'b0;
    e    = '0;
    if (c == 0) begin
      if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
    end else begin
      if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
    end
    n_cmp++;
    if (!have) begin
      n_err++;
      $display("FAIL data_ok_unexpected ch%0d: got pulse, required none", c);
    end else if (e.is_rd && (act !== e.data)) begin
      n_err++;
      $display("FAIL rdata ch%0d: got %h, required %h", c, act, e.data);
    end
  endtask

  // Scoreboard monitor: every completion pulse is matched against the channel's queue.
  always @(negedge aclk) begin
    if (aresetn === 1'b1) begin
      for (int c = 0; c < NCH; c++) begin
        if (ch_data_ok[c] === 1'b1) mon_check(c, ch_rdata[c*32 +: 32]);
      end
    end
  end

  task automatic cyc();
    @(posedge aclk);
    #1;
  endtask

  task automatic mid();
    @(negedge aclk);
  endtask

  task automatic set_rd(input int c, input logic [31:0] a);
    ch_wr[c]           = 1'b0;
    ch_addr[c*32 +: 32] = a;
    ch_size[c*2 +: 2]   = 2'd2;
  endtask

  task automatic set_wr(input int c, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    ch_wr[c]            = 1'b1;
    ch_addr[c*32 +: 32]  = a;
    ch_size[c*2 +: 2]    = 2'd2;
    ch_wstrb[c*4 +: 4]   = s;
    ch_wdata[c*32 +: 32] = d;
  endtask

  logic [1:0] exp_gnt;
  int         ngrants;
  logic       hs_prev;
  logic [1:0] hs_id;
  int         rsp_n;

  initial begin
    aresetn = 1'b0;
    ch_req = '0; ch_wr = '0; ch_size = '0; ch_addr = '0; ch_wstrb = '0; ch_wdata = '0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bid = '0; bresp = '0; bvalid = 1'b0;

    // Reset state, with a pending request that must not be accepted.
    set_rd(0, 32'h0000_0040);
    ch_req = 2'b01;
    mid();
    chk("rst_addr_ok", ch_addr_ok, 0);
    chk("rst_arvalid", arvalid, 0);
    chk("rst_awvalid", awvalid, 0);
    chk("rst_wvalid", wvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_bready", bready, 0);
    chk("rst_data_ok", ch_data_ok, 0);
    chk("rst_rdata", ch_rdata, 0);
    ch_req = '0;
    cyc();
    aresetn = 1'b1;
    mid();
    chk("rready_before_edge", rready, 0);

    // Single read on ch0.
    cyc();
    set_rd(0, 32'h1c00_0000);
    ch_req = 2'b01;
    mid();
    chk("rd1_addr_ok", ch_addr_ok, 32'h1);
    chk("rd1_arvalid_T", arvalid, 0);
    chk("rready_after_edge", rready, 1);
    cyc();
    ch_req = '0;
    arready = 1'b1;
    mid();
    chk("rd1_arvalid", arvalid, 1);
    chk("rd1_araddr", araddr, 32'h1c00_0000);
    chk("rd1_arid", arid, 0);
    chk("rd1_arsize", arsize, 3'd2);
    chk("rd1_arlen", arlen, 0);
    chk("rd1_arburst", arburst, 2'b01);
    cyc();
    arready = 1'b0;
    mid();
    chk("rd1_arvalid_drop", arvalid, 0);
    cyc();
    cyc();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hDEAD_BEEF;
    push_exp(0, 1'b1, 32'hDEAD_BEEF);
    mid();
    chk("rd1_data_ok_early", ch_data_ok, 0);
    cyc();
    rvalid = 1'b0;
    mid();
    chk("rd1_data_ok", ch_data_ok, 32'h1);

    // Both channels reading continuously; rd_ptr is 1 after the ch0 grant.
    exp_gnt = 2'b10;
    ngrants = 0;
    hs_prev = 1'b0;
    hs_id   = '0;
    rsp_n   = 0;
    arready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      cyc();
      if (c == 0) begin
        set_rd(0, 32'h1000_0000);
        set_rd(1, 32'h1000_0010);
        ch_req = 2'b11;
      end
      if (c == 16) ch_req = 2'b00;
      if (hs_prev) begin
        rvalid = 1'b1;
        rid    = {2'b00, hs_id};
        rdata  = 32'hA500_0000 | rsp_n;
        push_exp(int'(hs_id), 1'b1, 32'hA500_0000 | rsp_n);
        rsp_n++;
      end else begin
        rvalid = 1'b0;
      end
      mid();
      if (ch_addr_ok != 2'b00) begin
        chk("rr_grant", ch_addr_ok, exp_gnt);
        exp_gnt = ~exp_gnt;
        ngrants++;
      end
      hs_prev = arvalid & arready;
      hs_id   = arid[1:0];
    end
    chk("rr_grant_count", ngrants, 8);
    cyc();
    arready = 1'b0;
    rvalid  = 1'b0;

    // ch1 write, W handshake two cycles before AW.
    cyc();
    set_wr(1, 32'h0000_0100, 4'b0011, 32'h1234_5678);
    ch_req = 2'b10;
    mid();
    chk("wr1_addr_ok", ch_addr_ok, 32'h2);
    cyc();
    ch_req = '0;
    wready = 1'b1;
    mid();
    chk("wr1_awvalid", awvalid, 1);
    chk("wr1_wvalid", wvalid, 1);
    chk("wr1_awid", awid, 1);
    chk("wr1_wid", wid, 1);
    chk("wr1_awaddr", awaddr, 32'h100);
    chk("wr1_wstrb", wstrb, 4'b0011);
    chk("wr1_wdata", wdata, 32'h1234_5678);
    chk("wr1_wlast", wlast, 1);
    chk("wr1_bready_early", bready, 0);
    cyc();
    wready = 1'b0;
    mid();
    chk("wr1_wvalid_drop", wvalid, 0);
    chk("wr1_awvalid_held", awvalid, 1);
    cyc();
    awready = 1'b1;
    mid();
    chk("wr1_awvalid_hs", awvalid, 1);
    cyc();
    awready = 1'b0;
    mid();
    chk("wr1_awvalid_drop", awvalid, 0);
    chk("wr1_bready", bready, 1);
    cyc();
    bvalid = 1'b1;
    push_exp(1, 1'b0, 32'h0);
    mid();
    chk("wr1_data_ok_early", ch_data_ok, 0);
    cyc();
    bvalid = 1'b0;
    mid();
    chk("wr1_data_ok", ch_data_ok, 32'h2);
    chk("wr1_bready_drop", bready, 0);

    // Read-after-write hazard on the same word.
    cyc();
    set_wr(1, 32'h0000_0200, 4'b1111, 32'hAAAA_5555);
    ch_req = 2'b10;
    mid();
    chk("hz_wr_addr_ok", ch_addr_ok, 32'h2);
    cyc();
    set_rd(0, 32'h0000_0202);
    ch_req = 2'b01;
    awready = 1'b1; wready = 1'b1;
    mid();
    chk("hz_blocked_wreq", ch_addr_ok, 0);
    cyc();
    awready = 1'b0; wready = 1'b0;
    mid();
    chk("hz_blocked_wresp0", ch_addr_ok, 0);
    cyc();
    mid();
    chk("hz_blocked_wresp1", ch_addr_ok, 0);
    cyc();
    bvalid = 1'b1;
    push_exp(1, 1'b0, 32'h0);
    mid();
    chk("hz_blocked_bvalid", ch_addr_ok, 0);
    cyc();
    bvalid = 1'b0;
    mid();
    chk("hz_released", ch_addr_ok, 32'h1);
    chk("hz_wr_data_ok", ch_data_ok, 32'h2);
    cyc();
    ch_req = '0;
    arready = 1'b1;
    mid();
    chk("hz_araddr", araddr, 32'h0000_0202);
    cyc();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0BAD_F00D;
    push_exp(0, 1'b1, 32'h0BAD_F00D);
    cyc();
    rvalid = 1'b0;
    mid();
    chk("hz_rd_data_ok", ch_data_ok, 32'h1);

    // Different word during an outstanding write: no blocking; same-cycle completions.
    cyc();
    set_wr(1, 32'h0000_0200, 4'b1111, 32'h5555_AAAA);
    ch_req = 2'b10;
    mid();
    chk("nohz_wr_addr_ok", ch_addr_ok, 32'h2);
    cyc();
    set_rd(0, 32'h0000_0300);
    ch_req = 2'b01;
    awready = 1'b1; wready = 1'b1;
    mid();
    chk("nohz_rd_addr_ok", ch_addr_ok, 32'h1);
    cyc();
    ch_req = '0;
    awready = 1'b0; wready = 1'b0;
    arready = 1'b1;
    mid();
    chk("nohz_araddr", araddr, 32'h0000_0300);
    cyc();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hCAFE_F00D;
    push_exp(0, 1'b1, 32'hCAFE_F00D);
    bvalid = 1'b1;
    push_exp(1, 1'b0, 32'h0);
    cyc();
    rvalid = 1'b0; bvalid = 1'b0;
    mid();
    chk("both_data_ok", ch_data_ok, 32'h3);

    // Out-of-order read responses; rd_ptr is 1 here.
    cyc();
    set_rd(0, 32'h0000_1000);
    ch_req = 2'b01;
    mid();
    chk("ooo_gnt0", ch_addr_ok, 32'h1);
    cyc();
    set_rd(1, 32'h0000_2000);
    ch_req = 2'b10;
    arready = 1'b1;
    mid();
    chk("ooo_slot_full", ch_addr_ok, 0);
    chk("ooo_arid0", arid, 0);
    cyc();
    mid();
    chk("ooo_gnt1", ch_addr_ok, 32'h2);
    cyc();
    ch_req = '0;
    mid();
    chk("ooo_arid1", arid, 1);
    chk("ooo_araddr1", araddr, 32'h0000_2000);
    cyc();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_1111;
    push_exp(1, 1'b1, 32'h1111_1111);
    cyc();
    rid = 4'd0; rdata = 32'h2222_0000;
    push_exp(0, 1'b1, 32'h2222_0000);
    mid();
    chk("ooo_data_ok1", ch_data_ok, 32'h2);
    cyc();
    rid = 4'd1; rdata = 32'hBAD0_0001;
    mid();
    chk("ooo_data_ok0", ch_data_ok, 32'h1);
    cyc();
    rid = 4'd3; rdata = 32'hBAD0_0003;
    mid();
    chk("drop_idle_rid", ch_data_ok, 0);
    cyc();
    rvalid = 1'b0;
    mid();
    chk("drop_bad_rid", ch_data_ok, 0);

    // Reset with AR pending and the write FSM waiting for B.
    cyc();
    set_rd(0, 32'h0000_0400);
    set_wr(1, 32'h0000_0500, 4'b1111, 32'h0F0F_0F0F);
    ch_req = 2'b11;
    mid();
    chk("rst6_dual_grant", ch_addr_ok, 32'h3);
    cyc();
    ch_req = '0;
    awready = 1'b1; wready = 1'b1;
    mid();
    chk("rst6_arvalid", arvalid, 1);
    cyc();
    awready = 1'b0; wready = 1'b0;
    mid();
    chk("rst6_arvalid_held", arvalid, 1);
    chk("rst6_bready", bready, 1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("rst6_arvalid_clr", arvalid, 0);
    chk("rst6_awvalid_clr", awvalid, 0);
    chk("rst6_wvalid_clr", wvalid, 0);
    chk("rst6_bready_clr", bready, 0);
    chk("rst6_rready_clr", rready, 0);
    chk("rst6_data_ok_clr", ch_data_ok, 0);
    chk("rst6_rdata_clr", ch_rdata, 0);
    cyc();
    cyc();
    aresetn = 1'b1;
    cyc();
    set_rd(0, 32'h1c00_0040);
    ch_req = 2'b01;
    mid();
    chk("post_rst_gnt", ch_addr_ok, 32'h1);
    cyc();
    ch_req = '0;
    arready = 1'b1;
    mid();
    chk("post_rst_araddr", araddr, 32'h1c00_0040);
    cyc();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h600D_0001;
    push_exp(0, 1'b1, 32'h600D_0001);
    cyc();
    rvalid = 1'b0;
    mid();
    chk("post_rst_data_ok", ch_data_ok, 32'h1);

    cyc();
    cyc();
    mid();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_bridge_nch.md
# axi_bridge_nch

Parametrised multi-channel bridge from NUM_CH SRAM-like request ports (instruction fetch, data, future TLB/cache-refill clients) to a single AXI3 master port. It sits between cpu_core and the AXI interconnect, replacing the fixed two-port bridge. It adds round-robin arbitration, per-channel AXI IDs, concurrent read and write, and read-after-write address hazard blocking.

## Interface
- NUM_CH, 2, number of SRAM-like channels (1..4); channel i uses AXI ID i
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- ch_req  in  NUM_CH  request valid per channel
- ch_wr  in  NUM_CH  1 = write, 0 = read
- ch_size  in  2*NUM_CH  bytes = 1<<size (0,1,2)
- ch_addr  in  32*NUM_CH  byte address
- ch_wstrb  in  4*NUM_CH  write byte strobes
- ch_wdata  in  32*NUM_CH  write data
- ch_addr_ok  out  NUM_CH  request accepted this cycle
- ch_data_ok  out  NUM_CH  read data valid / write completed (1-cycle pulse)
- ch_rdata  out  32*NUM_CH  read data, valid with ch_data_ok
- arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot  out  4/32/8/3/2/2/4/3  read address
- arvalid  out  1; arready  in  1
- rid/rdata/rresp/rlast/rvalid  in  4/32/2/1/1; rready  out  1
- awid/awaddr/awlen/awsize/awburst/awlock/awcache/awprot  out  4/32/8/3/2/2/4/3  write address
- awvalid  out  1; awready  in  1
- wid/wdata/wstrb/wlast/wvalid  out  4/32/4/1/1; wready  in  1
- bid/bresp/bvalid  in  4/2/1; bready  out  1

## Operation
- Constants: arlen=awlen=0, arburst=awburst=2'b01, lock/cache/prot=0, wlast=1; arsize/awsize={1'b0,size}. rresp, rlast, bresp, bid ignored.
- busy[i]: set on grant to channel i, cleared on its data_ok. Busy channel never granted; one outstanding transaction per channel.
- Read arbiter: candidates = ch_req & ~ch_wr & ~busy & ~hazard; grant only when AR slot empty (arvalid=0). Round-robin: search from rd_ptr upward, wrap; on grant rd_ptr = (i+1) mod NUM_CH.
- Write arbiter: candidates = ch_req & ch_wr & ~busy; grant only in W_IDLE; separate wr_ptr, same rule.
- Read and write grants to different channels in the same cycle both allowed.
- Grant: ch_addr_ok[i]=1 combinationally that cycle; addr/size/wstrb/wdata captured into registers.
- AR: arvalid set next cycle with arid=i, held stable until arready; cleared the cycle after handshake.
- R: rready=1 out of reset. On rvalid with rid=j and busy[j] set by a read: ch_rdata[j]=rdata and ch_data_ok[j]=1 next cycle (registered, one cycle). rid of a non-busy channel is dropped.
- Write FSM: W_IDLE -> W_REQ on grant (awvalid=wvalid=1, awid=wid=i; each deasserted independently after its own handshake) -> W_RESP when both handshakes done (bready=1) -> W_IDLE on bvalid; ch_data_ok[owner] pulses the cycle after bvalid.
- Hazard: while write FSM not in W_IDLE, a read with addr[31:2] == write addr[31:2] is not a candidate; it waits (addr_ok=0) until W_IDLE.
- Unsigned arithmetic; pointer wrap mod NUM_CH (NUM_CH=1: pointer constant 0).

## Timing
- Reset (async assert): arvalid, awvalid, wvalid, rready, bready, ch_addr_ok, ch_data_ok = 0; busy=0; pointers=0; FSM=W_IDLE; ch_rdata=0. rready=1 from the first edge after deassert. Reset mid-transaction abandons all AXI traffic.
- Read: req at T -> addr_ok T, arvalid T+1; arready at T+k -> arvalid low T+k+1; rvalid at R -> data_ok R+1. Next read grant earliest T+k+1.
- Write: grant at T -> aw/wvalid T+1; bvalid at B -> data_ok B+1, W_IDLE at B+1, next write grant B+1, hazard cleared B+1.
- awready and wready may arrive in any order or same cycle.
- Same-cycle data_ok for read and write to different channels allowed.

## Test plan
- NUM_CH=2, ch0 read 0x1c000000, arready immediate, rvalid rid=0 data 0xDEADBEEF 3 cycles later -> addr_ok[0] at T, arvalid T+1, data_ok[0] with rdata 0xDEADBEEF one cycle after rvalid.
- ch0 and ch1 reads held continuously, each completing -> grants alternate 0,1,0,1; neither starves.
- ch1 write 0x100 wstrb 4'b0011, wready 2 cycles before awready -> wvalid drops first, awvalid later, bvalid -> data_ok[1] next cycle, awid=wid=1.
- ch1 write to 0x200 outstanding, ch0 read 0x202 -> addr_ok[0] held 0 until cycle after bvalid; read 0x300 instead granted immediately.
- Out-of-order responses: ch0 and ch1 reads issued, rvalid rid=1 before rid=0 -> data_ok[1] then data_ok[0] with correct data each.
- aresetn low while arvalid=1 and W_RESP -> all valids and data_ok 0 immediately; after release, fresh read completes normally.
